// File: rtl/top_edge_preserving_filter.sv
// ---------------------------------------------------------------------------
// top_edge_preserving_filter
//
// Edge-preserving denoise engine for 8-bit grayscale frames. A start pulse
// scans the zero-padded (IMG_H+2)x(IMG_W+2) frame held in the internal image
// memory. Each 3x3 neighbourhood is smoothed along whichever of the four
// directions through its centre (horizontal, vertical, 45, 135 degrees)
// shows the smallest intensity change. Edges therefore keep their
// sharpness while flat areas are averaged. The IMG_H x IMG_W result lands
// in the internal output memory.
//
// Ports:
//   clk    in   rising-edge clock for all logic
//   rst_n  in   asynchronous active-low reset
//   en     in   start request, sampled while idle or done
//   done   out  level flag, high once the whole frame has been written
//
// Hierarchy: instance "mem" (EpfFrameMem) holds Mem_img (input frame,
// loaded from outside) and Mem_fil_img (filtered output frame).
//
// Build option: define EPF_ROUND_EN for round-to-nearest averaging (+2
// before the divide by four). Leave it undefined for plain truncation.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// EpfFrameMem
//
// Frame storage for the filter. The padded input frame is read through nine
// combinational ports that together form the 3x3 window whose top-left
// corner is (rdRow_i, rdCol_i). The output frame has one synchronous write
// port. Neither array is reset, so contents survive a reset of the engine.
//
// Ports:
//   clk       in   write clock
//   wrEn_i    in   write strobe for Mem_fil_img
//   wrRow_i   in   output row being written
//   wrCol_i   in   output column being written
//   wrData_i  in   filtered pixel value
//   rdRow_i   in   window top row in the padded frame
//   rdCol_i   in   window left column in the padded frame
//   win_o     out  3x3 window, indexed [row offset][column offset]
// ---------------------------------------------------------------------------
module EpfFrameMem #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int DW    = 8
) (
    input  logic                             clk,
    input  logic                             wrEn_i,
    input  logic [$clog2(IMG_H)-1:0]         wrRow_i,
    input  logic [$clog2(IMG_W)-1:0]         wrCol_i,
    input  logic [DW-1:0]                    wrData_i,
    input  logic [$clog2(IMG_H+2)-1:0]       rdRow_i,
    input  logic [$clog2(IMG_W+2)-1:0]       rdCol_i,
    output logic [2:0][2:0][DW-1:0]          win_o
);

    localparam int PRW = $clog2(IMG_H + 2);
    localparam int PCW = $clog2(IMG_W + 2);

    logic [DW-1:0] Mem_img     [0:IMG_H+1][0:IMG_W+1];
    logic [DW-1:0] Mem_fil_img [0:IMG_H-1][0:IMG_W-1];

    // Nine combinational taps. The engine never issues a window that would
    // run past the padded border, so the offsets cannot wrap.
    for (genvar i = 0; i < 3; i++) begin : gWinRow
        for (genvar j = 0; j < 3; j++) begin : gWinCol
            assign win_o[i][j] = Mem_img[rdRow_i + PRW'(i)][rdCol_i + PCW'(j)];
        end
    end

    // Output pixels are written one cycle after their window was evaluated.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            Mem_fil_img[wrRow_i][wrCol_i] <= wrData_i;
        end
    end

endmodule

module top_edge_preserving_filter #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int DW    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic done
);

    localparam int RH  = $clog2(IMG_H);
    localparam int CH  = $clog2(IMG_W);
    localparam int PRW = $clog2(IMG_H + 2);
    localparam int PCW = $clog2(IMG_W + 2);

`ifdef EPF_ROUND_EN
    localparam logic [DW+1:0] ROUND_K = (DW+2)'(2);
`else
    localparam logic [DW+1:0] ROUND_K = '0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [RH-1:0]   row_q, row_d;
    logic [CH-1:0]   col_q, col_d;
    logic            drain_q, drain_d;

    logic            vld_q, vld_d;
    logic [DW-1:0]   res_q, res_d;
    logic [RH-1:0]   wrRow_q;
    logic [CH-1:0]   wrCol_q;

    logic                    issue;
    logic                    lastPix;
    logic [2:0][2:0][DW-1:0] win;
    logic [DW-1:0]           cen;
    logic [3:0][DW-1:0]      p1;
    logic [3:0][DW-1:0]      p2;
    logic [3:0][DW-1:0]      act;
    logic [1:0]              sel;
    logic [DW+1:0]           sum;

    EpfFrameMem #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .DW    (DW)
    ) mem (
        .clk      (clk),
        .wrEn_i   (vld_q),
        .wrRow_i  (wrRow_q),
        .wrCol_i  (wrCol_q),
        .wrData_i (res_q),
        .rdRow_i  (PRW'(row_q)),
        .rdCol_i  (PCW'(col_q)),
        .win_o    (win)
    );

    assign lastPix = (row_q == RH'(IMG_H - 1)) && (col_q == CH'(IMG_W - 1));

    // drain_q marks that the final pixel has been issued; the RUN state then
    // waits exactly one cycle for its write before declaring the frame done.
    assign issue = (state_q == RUN) && !drain_q;

    assign done = (state_q == DONE);

    // Raster scan control: column fastest, one pixel issued per cycle.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        drain_d = drain_q;
        case (state_q)
            IDLE, DONE: begin
                if (en) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                    drain_d = 1'b0;
                end
            end
            RUN: begin
                if (drain_q) begin
                    state_d = DONE;
                    drain_d = 1'b0;
                end else if (lastPix) begin
                    drain_d = 1'b1;
                end else if (col_q == CH'(IMG_W - 1)) begin
                    col_d = '0;
                    row_d = row_q + RH'(1);
                end else begin
                    col_d = col_q + CH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            drain_q <= drain_d;
        end
    end

    // Direction pairs through the centre, index 0..3 = H, V, D45, D135.
    assign cen   = win[1][1];
    assign p1[0] = win[1][0];
    assign p2[0] = win[1][2];
    assign p1[1] = win[0][1];
    assign p2[1] = win[2][1];
    assign p1[2] = win[2][0];
    assign p2[2] = win[0][2];
    assign p1[3] = win[0][0];
    assign p2[3] = win[2][2];

    // Absolute difference through a signed-width intermediate: the extra
    // top bit of the subtraction tells which operand was larger.
    function automatic logic [DW-1:0] absDiff(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW:0] d;
        logic [DW:0] n;
        d = {1'b0, a} - {1'b0, b};
        n = -d;
        return d[DW] ? n[DW-1:0] : d[DW-1:0];
    endfunction

    for (genvar k = 0; k < 4; k++) begin : gAct
        assign act[k] = absDiff(p1[k], p2[k]);
    end

    // Minimum-activity direction. Each test uses <= so that on a tie the
    // earlier direction wins, giving the H > V > D45 > D135 priority.
    always_comb begin
        sel = 2'd3;
        if ((act[0] <= act[1]) && (act[0] <= act[2]) && (act[0] <= act[3])) begin
            sel = 2'd0;
        end else if ((act[1] <= act[2]) && (act[1] <= act[3])) begin
            sel = 2'd1;
        end else if (act[2] <= act[3]) begin
            sel = 2'd2;
        end
    end

    // Weighted 1-2-1 average along the chosen direction. The sum peaks at
    // 4*(2^DW-1)+2, so the quotient always fits in DW bits.
    always_comb begin
        sum   = {2'b00, p1[sel]} + {1'b0, cen, 1'b0} + {2'b00, p2[sel]} + ROUND_K;
        res_d = DW'(sum >> 2);
        vld_d = issue;
    end

    // Single pipeline stage between window evaluation and the memory write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            res_q   <= '0;
            wrRow_q <= '0;
            wrCol_q <= '0;
        end else begin
            vld_q   <= vld_d;
            res_q   <= res_d;
            wrRow_q <= row_q;
            wrCol_q <= col_q;
        end
    end

endmodule

// File: tb/tb_top_edge_preserving_filter.sv
// ---------------------------------------------------------------------------
// tb_top_edge_preserving_filter
//
// Self-checking bench for top_edge_preserving_filter, run on a reduced
// 16x16 frame so that several complete frames fit in a short simulation.
// Expected pixels come from a behavioural model of the filter and are
// queued when a run is started, then popped and compared against the
// output memory once the run has finished. Honours EPF_ROUND_EN in the
// same way as the design.
// ---------------------------------------------------------------------------
module tb_top_edge_preserving_filter;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int DW = 8;
    localparam int N  = W * H;

`ifdef EPF_ROUND_EN
    localparam int K = 2;
`else
    localparam int K = 0;
`endif

    typedef struct {
        int r;
        int c;
        int v;
    } expEntry_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic done;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int e0          = 0;

    expEntry_t expQ[$];
    int img      [0:H+1][0:W+1];
    int filModel [0:H-1][0:W-1];

    top_edge_preserving_filter #(
        .IMG_W (W),
        .IMG_H (H),
        .DW    (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference filter for one output pixel, from the bench's copy of the frame.
    function automatic int modelPixel(input int r, input int c);
        int p1[4];
        int p2[4];
        int act[4];
        int best;
        int cen;
        cen   = img[r+1][c+1];
        p1[0] = img[r+1][c];   p2[0] = img[r+1][c+2];
        p1[1] = img[r][c+1];   p2[1] = img[r+2][c+1];
        p1[2] = img[r+2][c];   p2[2] = img[r][c+2];
        p1[3] = img[r][c];     p2[3] = img[r+2][c+2];
        best = 0;
        for (int d = 0; d < 4; d++) begin
            act[d] = (p1[d] > p2[d]) ? p1[d] - p2[d] : p2[d] - p1[d];
            if (act[d] < act[best]) best = d;
        end
        return (p1[best] + 2 * cen + p2[best] + K) / 4;
    endfunction

    task automatic loadFrame();
        for (int r = 0; r < H + 2; r++) begin
            for (int c = 0; c < W + 2; c++) begin
                dut.mem.Mem_img[r][c] = 8'(img[r][c]);
            end
        end
    endtask

    // Pulses en and queues the expected output memory. Pixels up to
    // lastFresh must hold new results; pixels from firstStale on must keep
    // their previous contents; anything in between is not checked.
    task automatic applyStimulus(input int lastFresh, input int firstStale);
        expEntry_t e;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        e0 = cyc;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                e.r = r;
                e.c = c;
                if (r * W + c <= lastFresh) begin
                    filModel[r][c] = modelPixel(r, c);
                    e.v = filModel[r][c];
                    expQ.push_back(e);
                end else if (r * W + c >= firstStale) begin
                    e.v = filModel[r][c];
                    expQ.push_back(e);
                end else begin
                    filModel[r][c] = -1;
                end
            end
        end
    endtask

    task automatic waitEdges(input int n);
        while (cyc - e0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDone(input string tag);
        while (!done && (cyc - e0 < N + 2)) begin
            @(posedge clk);
            #1;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic drainCompare(input string tag);
        expEntry_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(tag, 32'(dut.mem.Mem_fil_img[e.r][e.c]), e.v);
        end
    endtask

    task automatic fillFlat(input int v);
        for (int r = 0; r < H + 2; r++)
            for (int c = 0; c < W + 2; c++)
                img[r][c] = v;
    endtask

    task automatic fillRandom();
        for (int r = 0; r < H + 2; r++)
            for (int c = 0; c < W + 2; c++)
                img[r][c] = int'($urandom_range(0, 255));
    endtask

    initial begin
        // Reset and idle behaviour
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle_done", 32'(done), 32'd0);

        // Flat frame: every output equals the flat level
        fillFlat(100);
        loadFrame();
        applyStimulus(N - 1, N);
        checkOutput("run_started_done_low", 32'(done), 32'd0);
        waitDone("flat_done");
        drainCompare("flat_pixel");
        repeat (5) @(posedge clk);
        #1;
        checkOutput("done_level", 32'(done), 32'd1);

        // Impulse, started from DONE
        fillFlat(50);
        img[10][10] = 250;
        loadFrame();
        applyStimulus(N - 1, N);
        checkOutput("restart_done_drop", 32'(done), 32'd0);
        waitDone("impulse_done");
        checkOutput("impulse_9_9", 32'(dut.mem.Mem_fil_img[9][9]), 32'd150);
        checkOutput("impulse_9_8", 32'(dut.mem.Mem_fil_img[9][8]), 32'd50);
        checkOutput("impulse_8_9", 32'(dut.mem.Mem_fil_img[8][9]), 32'd50);
        drainCompare("impulse_pixel");

        // Vertical edge is kept sharp
        for (int r = 0; r < H + 2; r++)
            for (int c = 0; c < W + 2; c++)
                img[r][c] = (c <= W / 2) ? 20 : 200;
        loadFrame();
        applyStimulus(N - 1, N);
        waitDone("vedge_done");
        for (int r = 0; r < H; r++) begin
            checkOutput("vedge_left", 32'(dut.mem.Mem_fil_img[r][W/2-1]), 32'd20);
            checkOutput("vedge_right", 32'(dut.mem.Mem_fil_img[r][W/2]), 32'd200);
        end
        drainCompare("vedge_pixel");

        // Rounding versus truncation
        fillFlat(10);
        img[1][1] = 11;
        loadFrame();
        applyStimulus(N - 1, N);
        waitDone("round_done");
        checkOutput("round_0_0", 32'(dut.mem.Mem_fil_img[0][0]), (K == 2) ? 32'd11 : 32'd10);
        drainCompare("round_pixel");

        // Random frame with a stray en pulse mid-run
        fillRandom();
        loadFrame();
        applyStimulus(N - 1, N);
        waitEdges(50);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        waitEdges(N - 1);
        checkOutput("no_early_done", 32'(done), 32'd0);
        waitDone("midrun_en_done");
        drainCompare("random_pixel");

        // Reset in the middle of a run: earlier writes stay, later pixels untouched
        fillRandom();
        loadFrame();
        applyStimulus(96, 102);
        waitEdges(100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort_idle_done", 32'(done), 32'd0);
        drainCompare("abort_pixel");

        // A fresh start after the abort completes the frame
        applyStimulus(N - 1, N);
        waitDone("rerun_done");
        drainCompare("rerun_pixel");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/top_edge_preserving_filter.md
# top_edge_preserving_filter

Self-contained 8-bit grayscale edge-preserving denoise engine for the video noise-reduction datapath. On an `en` pulse it scans a zero-padded 258×258 frame held in its internal image memory. Each 3×3 neighbourhood is replaced by a directional smoothing along the direction of least intensity change. The 256×256 result is written into an internal output memory, and `done` is raised when the frame is complete.

## Interface
- `IMG_W`, 256, output frame width in pixels; the input frame is IMG_W+2 wide.
- `IMG_H`, 256, output frame height in pixels; the input frame is IMG_H+2 high.
- `DW`, 8, pixel width in bits (unsigned).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  start request; sampled on a rising edge while idle.
- `done`  out  1  frame-complete flag.
- Internal instance `mem` is part of the verification interface. It holds:
  - `Mem_img[0:IMG_H+1][0:IMG_W+1]`: input, loaded hierarchically by the bench.
  - `Mem_fil_img[0:IMG_H-1][0:IMG_W-1]`: output.
  - Both are DW bits per pixel, row index first.

## Operation
- States:
  - IDLE: `en`=1 moves to RUN and clears the row/col counters.
  - RUN: processes one pixel per cycle, raster order, col fastest. After output pixel (IMG_H-1, IMG_W-1) is written, moves to DONE.
  - DONE: `done`=1. `en`=1 restarts a run (counters cleared, `done` dropped); otherwise the block stays in DONE.
- Window for output (r,c) is `Mem_img[r..r+2][c..c+2]`, with centre C=`Mem_img[r+1][c+1]`.
- Direction pairs (P1,P2) through the centre:
  - H = (r+1,c),(r+1,c+2)
  - V = (r,c+1),(r+2,c+1)
  - D45 = (r+2,c),(r,c+2)
  - D135 = (r,c),(r+2,c+2)
- Per-direction activity is |P1−P2|, an unsigned 9-bit intermediate giving an 8-bit magnitude.
- The direction with the minimum activity is selected. Ties resolve with priority H > V > D45 > D135.
- Output = (P1 + 2·C + P2 + k) >> 2, computed in a 10-bit sum, with k per Configuration. The result always fits in DW bits, so no saturation is needed.
- Input memory is read combinationally (9 reads per cycle). The output memory is written synchronously.
- `en` while in RUN is ignored.
- Reset behaviour:
  - Returns the block to IDLE, clears the counters and the pipeline valid bit, and drives `done`=0.
  - Does not clear `Mem_img` or `Mem_fil_img`.
  - Reset mid-run aborts the run. Already-written output pixels remain, and no further writes occur until a new `en`.

## Timing
- Reset values: `done`=0, state IDLE, counters 0.
- Pipeline is one stage. The window is evaluated and the result registered in cycle t, then written to `Mem_fil_img` at the edge of cycle t+1.
- `en` sampled at edge E0:
  - The first output write occurs by edge E0+2.
  - The last write occurs by edge E0+IMG_W·IMG_H+1.
  - `done` rises no later than E0+IMG_W·IMG_H+2, i.e. 65538 cycles for the defaults.
- A full frame needs at most 65540 cycles after `en` before the output memory is checked.
- `done` is a level: it stays high until reset or a new `en`.

## Configuration
- `EPF_ROUND_EN` defined: k=2, giving rounded averaging.
- `EPF_ROUND_EN` undefined: k=0, giving truncation.
- The golden frame for the noise-reduction flow is produced with `EPF_ROUND_EN` defined.

## Test plan
- Flat frame, all `Mem_img`=100; `en` one-cycle pulse → after 65540 cycles every `Mem_fil_img` entry is 100 and `done`=1.
- Impulse: all 50 except `Mem_img[10][10]`=250 →
  - `Mem_fil_img[9][9]`=150 (H chosen by tie priority).
  - `Mem_fil_img[9][8]`=50 and `Mem_fil_img[8][9]`=50 (V or H chosen by minimum activity).
- Vertical edge: padded cols 0..128 = 20 and cols 129..257 = 200 →
  - Output col 127 is 20 and col 128 is 200 on every row (V chosen, edge not blurred).
- Rounding: flat frame of 10 except `Mem_img[1][1]`=11 →
  - `Mem_fil_img[0][0]` = (10+22+10+2)>>2 = 11 with `EPF_ROUND_EN`.
  - `Mem_fil_img[0][0]` = (10+22+10)>>2 = 10 without it.
- Control:
  - `en` re-pulsed mid-run has no effect; `done` still rises at the nominal cycle.
  - `rst_n` low at cycle 1000 gives `done`=0, and entries written after the reset are unchanged from their prior values.
  - A new `en` completes the frame correctly.
- Random noisy padded frame → `Mem_fil_img` matches the C reference model bit-exactly, and `done` is high within 65540 cycles.
